// File: rtl/tetris_pkg.sv
// Shared board constants, row state codes and the row-clear sequencer state type.
package tetris_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  localparam logic [2:0] ST_CHECK = 3'b000;
  localparam logic [2:0] ST_MOVE  = 3'b001;
  localparam logic [2:0] ST_WRITE = 3'b010;
  localparam logic [2:0] ST_SHIFT = 3'b011;
  localparam logic [2:0] ST_ADD   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_DONE    = 3'd4
  } clr_state_e;

endpackage

// File: rtl/low_prefix_mask.sv
// Lowest set bit of a mask as a one-hot, plus the prefix mask covering bits 0..k.
module low_prefix_mask #(
  parameter int W = 20
) (
  input  logic [W-1:0] i_mask,
  output logic [W-1:0] o_onehot,
  output logic [W-1:0] o_prefix
);

  logic [W-1:0] w_onehot;

  // Two's-complement trick isolates the lowest set bit.
  assign w_onehot = i_mask & (~i_mask + W'(1));
  assign o_onehot = w_onehot;
  assign o_prefix = (i_mask == '0) ? '0 : (w_onehot | (w_onehot - W'(1)));

endmodule

// File: rtl/row_clear_ctrl.sv
// Row-clear sequencer: one check cycle, flag capture, then one shift-down cycle
// per cleared row, topmost first.
module row_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS  = tetris_pkg::ROWS,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ROWS-1:0]  row_shift,
  output logic [2:0]       state_out,
  output logic [ROWS-1:0]  shift_row,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared
);

  // start is a level request sampled only in S_IDLE (never queued); busy covers
  // CHECK..SHIFT and done is a single-cycle pulse in S_DONE with busy low.
  clr_state_e       r_state;
  clr_state_e       w_next;
  logic [ROWS-1:0]  r_mask;
  logic [CNT_W-1:0] r_lines;
  logic [ROWS-1:0]  w_onehot;
  logic [ROWS-1:0]  w_prefix;
  logic             w_mask_nz;

  low_prefix_mask #(.W(ROWS)) u_low_prefix (
    .i_mask   (r_mask),
    .o_onehot (w_onehot),
    .o_prefix (w_prefix)
  );

  assign w_mask_nz     = (r_mask != '0);
  assign lines_cleared = r_lines;

  always_comb begin
    w_next    = r_state;
    state_out = ST_MOVE;
    shift_row = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CHECK;
      end
      S_CHECK: begin
        state_out = ST_CHECK;
        busy      = 1'b1;
        w_next    = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_mask_nz) begin
          state_out = ST_SHIFT;
          shift_row = w_prefix;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Shifting rows 0..k never disturbs rows below k, so remaining flags stay valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_mask <= row_shift;
    end else if (r_state == S_SHIFT && w_mask_nz) begin
      r_mask <= r_mask & ~w_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lines <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_lines <= '0;
    end else if (r_state == S_SHIFT && w_mask_nz && r_lines != CNT_W'(ROWS)) begin
      r_lines <= r_lines + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Scoreboard bench for row_clear_ctrl: directed clear passes with hand-computed
// shift masks, done latency and line counts.
module tb_row_clear_ctrl;

  localparam int ROWS  = 20;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [ROWS-1:0]  row_shift = '0;
  logic [2:0]       state_out;
  logic [ROWS-1:0]  shift_row;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] lines_cleared;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [ROWS-1:0] exp_shift_q[$];
  logic [31:0]     exp_lc_q[$];
  logic [31:0]     exp_cyc_q[$];
  logic [ROWS-1:0] mon_shift;
  logic [31:0]     mon_lc;
  logic [31:0]     mon_cyc;

  row_clear_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .row_shift     (row_shift),
    .state_out     (state_out),
    .shift_row     (shift_row),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT shows a shift cycle or a done pulse
  always @(negedge clk) begin
    if (reset) begin
      if (state_out == 3'b011) begin
        if (exp_shift_q.size() == 0) begin
          fail_msg("unexpected_shift", shift_row, 0);
        end else begin
          mon_shift = exp_shift_q.pop_front();
          chk("shift_row", shift_row, mon_shift);
          chk("busy_in_shift", busy, 1);
        end
      end else if (shift_row != '0) begin
        fail_msg("shift_row_outside_shift", shift_row, 0);
      end
      if (state_out == 3'b010) fail_msg("write_code_driven", state_out, 3'b001);
      if (done) begin
        if (exp_lc_q.size() == 0) begin
          fail_msg("unexpected_done", lines_cleared, 0);
        end else begin
          mon_lc  = exp_lc_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          chk("lines_cleared_at_done", lines_cleared, mon_lc);
          chk("done_latency_cycle", cyc, mon_cyc);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic wait_done(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == limit) fail_msg("done_timeout", cyc, 0);
  endtask

  // Driver: caller pushes expected shift masks; this pushes count and done cycle.
  task automatic run_pass(input logic [ROWS-1:0] mask, input int n, input bit wait_for_done);
    @(negedge clk);
    if (wait_for_done) begin
      exp_lc_q.push_back(n);
      exp_cyc_q.push_back(cyc + 4 + n);
    end
    start     = 1'b1;
    row_shift = '1;
    @(negedge clk);
    chk("check_state_code", state_out, 3'b000);
    chk("busy_in_check", busy, 1);
    chk("lines_cleared_zeroed", lines_cleared, 0);
    start     = 1'b0;
    row_shift = 20'h5A5A5;
    @(negedge clk);
    chk("capture_state_code", state_out, 3'b001);
    row_shift = mask;
    @(negedge clk);
    row_shift = ~mask;
    if (wait_for_done) begin
      wait_done(60);
      row_shift = '0;
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_lc);
    chk({tag, "_state_out"}, state_out, 3'b001);
    chk({tag, "_shift_row"}, shift_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_lines"}, lines_cleared, exp_lc);
  endtask

  initial begin
    logic [31:0] pfx;
    // Power-on reset
    repeat (2) @(negedge clk);
    check_idle("por", 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_por", 0);

    // No full rows
    run_pass(20'h00000, 0, 1'b1);

    // Single clear at bottom
    exp_shift_q.push_back(20'hFFFFF);
    run_pass(20'h80000, 1, 1'b1);
    @(negedge clk);
    check_idle("after_single", 1);

    // Rows 17 and 19
    exp_shift_q.push_back(20'h3FFFF);
    exp_shift_q.push_back(20'hFFFFF);
    run_pass(20'hA0000, 2, 1'b1);

    // Four-row clear, rows 16..19
    exp_shift_q.push_back(20'h1FFFF);
    exp_shift_q.push_back(20'h3FFFF);
    exp_shift_q.push_back(20'h7FFFF);
    exp_shift_q.push_back(20'hFFFFF);
    run_pass(20'hF0000, 4, 1'b1);

    // Top row and bottom row together
    exp_shift_q.push_back(20'h00001);
    exp_shift_q.push_back(20'hFFFFF);
    run_pass(20'h80001, 2, 1'b1);

    // Every row full: count reaches ROWS and holds
    for (int i = 0; i < ROWS; i++) begin
      pfx = (32'd1 << (i + 1)) - 32'd1;
      exp_shift_q.push_back(pfx[ROWS-1:0]);
    end
    run_pass(20'hFFFFF, 20, 1'b1);
    repeat (3) @(negedge clk);
    check_idle("hold_full_count", 20);

    // start held and toggled during a pass: exactly one pass and one done
    exp_shift_q.push_back(20'h3FFFF);
    exp_shift_q.push_back(20'hFFFFF);
    @(negedge clk);
    exp_lc_q.push_back(2);
    exp_cyc_q.push_back(cyc + 6);
    start = 1'b1;
    row_shift = '1;
    @(negedge clk);
    @(negedge clk);
    row_shift = 20'hA0000;
    @(negedge clk);
    start = 1'b0;
    row_shift = '1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    row_shift = '0;
    wait_done(20);
    repeat (4) @(negedge clk);
    check_idle("no_requeue", 2);

    // Reset in the middle of SHIFT
    exp_shift_q.push_back(20'h1FFFF);
    exp_shift_q.push_back(20'h3FFFF);
    run_pass(20'hF0000, 4, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_idle("async_reset", 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    row_shift = '0;
    repeat (3) @(negedge clk);
    check_idle("idle_after_mid_reset", 0);

    // Normal pass after the mid-pass reset
    exp_shift_q.push_back(20'h7FFFF);
    run_pass(20'h40000, 1, 1'b1);
    repeat (2) @(negedge clk);

    chk("shift_queue_drained", exp_shift_q.size(), 0);
    chk("done_queue_drained", exp_lc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/row_clear_ctrl.md
Name: row_clear_ctrl

Overview:
Sequencer on the control side of the board-row interface: drives the 3-bit row state code and per-row shift enables into the array of row registers, and consumes their per-row "shift" (row-cleared) flags. After a block is written, one clear pass runs: a check cycle makes full rows zero themselves, the returned flags are latched, and one shift-down cycle is issued per cleared row, topmost first. This handles multi-row clears without a per-row loop in the main game FSM.

Parameters:
ROWS, 20, number of board rows; index 0 = top, ROWS-1 = bottom
CNT_W, 5, width of lines_cleared; must hold ROWS

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request one clear pass; sampled only in IDLE
row_shift  in  ROWS  per-row cleared flags from the row array; valid the cycle after a check cycle
state_out  out  3  row state code broadcast to all rows
shift_row  out  ROWS  per-row shift-down enable; meaningful only while state_out = 011
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the pass completes
lines_cleared  out  CNT_W  rows removed in the last pass; holds until the next accepted start

Behaviour:
- Row state codes: 000 check, 001 move/hold, 010 write, 011 shift. This block drives only 000, 001 and 011, and never 010.
- Reset (reset = 0, asynchronous): FSM = IDLE, state_out = 001, shift_row = 0, busy = 0, done = 0, lines_cleared = 0, internal mask = 0.
- IDLE: state_out = 001. If start = 1, go to CHECK and clear lines_cleared to 0.
- CHECK (1 cycle): state_out = 000, busy = 1. Rows zero themselves and register their flags at this edge. Next state is CAPTURE.
- CAPTURE (1 cycle): state_out = 001. Latch mask <= row_shift. Next state is SHIFT.
- SHIFT: while mask != 0:
  - k = lowest set index in mask.
  - state_out = 011 and shift_row[i] = 1 for all i <= k, else 0. Row 0 takes a zero fill.
  - At the edge: clear mask[k] and increment lines_cleared.
  - Processing topmost first keeps the remaining indices valid, because shifting rows 0..k never moves rows below k.
- SHIFT with mask == 0: state_out = 001, shift_row = 0. Go to DONE.
- DONE (1 cycle): done = 1, busy = 0. Return to IDLE.
- Latency: with N cleared rows, done is asserted on cycle 3+N after the start edge. N = 0 gives 3 cycles.
- start while busy: ignored, with no queueing.
- row_shift outside CAPTURE: ignored.
- lines_cleared saturates at ROWS and never wraps.
- Reset mid-pass: return to IDLE immediately with all outputs at reset values. A partially compacted board is acceptable; the game FSM reinitialises the board on reset.
- shift_row is driven to 0 in every state except SHIFT with mask != 0.

Decomposition:
- Shared package tetris_pkg holds:
  - the row state code constants ST_CHECK = 3'b000, ST_MOVE = 3'b001, ST_WRITE = 3'b010, ST_SHIFT = 3'b011, ST_ADD = 3'b100;
  - the ROWS and COLS board constants;
  - the FSM state enum for this block.
- One combinational sub-module, low_prefix_mask: takes a ROWS-bit mask and outputs the one-hot lowest set bit plus the prefix mask (bits 0..k set). It is reused to clear mask[k].

Test Plan:
- Reset: hold reset = 0 mid-SHIFT, then release. Expect state_out = 001, shift_row = 0, busy = 0, done = 0, lines_cleared = 0; no activity until start.
- No full rows: start, row_shift = 0 in CAPTURE. Expect state_out sequence 000, 001, 001, then done on cycle 3 and lines_cleared = 0.
- Single clear at bottom: row_shift[19] = 1. Expect one SHIFT cycle with shift_row = all ones (20'hFFFFF), lines_cleared = 1, done on cycle 4.
- Multi-row: row_shift bits 17 and 19 set. Expect the first shift cycle with shift_row bits 0..17 set (20'h3FFFF), the second with bits 0..19 set (20'hFFFFF), then lines_cleared = 2 and done on cycle 5.
- Four-row clear (rows 16..19): expect 4 SHIFT cycles with prefix masks ending at 16, 17, 18 and 19; lines_cleared = 4.
- start held high during the pass and toggled mid-SHIFT: exactly one pass runs, one done pulse; a new pass begins only if start = 1 in IDLE afterwards.
